// File: rtl/drp_arbiter_if.sv
// Requester-side and DRP-side signal bundle for drp_arbiter.
// The arbiter connects through the slave modport; the requesters and the
// downstream DRP responder sit on the master side.
interface drp_arbiter_if #(
  parameter int NUM_PORTS = 4
) ();
  logic [NUM_PORTS-1:0]    req_en;
  logic [NUM_PORTS-1:0]    req_wr;
  logic [NUM_PORTS*9-1:0]  req_addr;
  logic [NUM_PORTS*16-1:0] req_wdata;
  logic [NUM_PORTS-1:0]    req_busy;
  logic [NUM_PORTS-1:0]    req_done;
  logic [15:0]             req_rdata;
  logic [NUM_PORTS-1:0]    req_timeout;
  logic                    drp_en;
  logic                    drp_wr;
  logic [8:0]              drp_addr;
  logic [15:0]             drp_wdata;
  logic [15:0]             drp_rdata;
  logic                    drp_done;

  modport slave (
    input  req_en, req_wr, req_addr, req_wdata, drp_rdata, drp_done,
    output req_busy, req_done, req_rdata, req_timeout,
           drp_en, drp_wr, drp_addr, drp_wdata
  );

  modport master (
    output req_en, req_wr, req_addr, req_wdata, drp_rdata, drp_done,
    input  req_busy, req_done, req_rdata, req_timeout,
           drp_en, drp_wr, drp_addr, drp_wdata
  );
endinterface

// File: rtl/drp_arbiter.sv
// Round-robin arbiter sharing one DRP register port among NUM_PORTS
// requesters. Each requester owns a one-deep request slot; transactions are
// serialised and a watchdog force-completes any transaction whose done never
// arrives so a hung transceiver cannot lock the bus.
module drp_arbiter #(
  parameter int          NUM_PORTS    = 4,
  parameter int          TIMEOUT      = 1023,
  parameter logic [15:0] TIMEOUT_DATA = 16'hdead
) (
  input  logic         clk,
  input  logic         rst,
  drp_arbiter_if.slave bus
);
  localparam int          GW      = $clog2(NUM_PORTS);
  localparam int          ADDR_W  = 9;
  localparam int          DATA_W  = 16;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [NUM_PORTS-1:0] slot_vld;
  logic                 slot_wr    [NUM_PORTS];
  logic [ADDR_W-1:0]    slot_addr  [NUM_PORTS];
  logic [DATA_W-1:0]    slot_wdata [NUM_PORTS];

  state_t               state;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        last_grant;
  logic [15:0]          to_cnt;

  logic                 drp_en_r;
  logic                 drp_wr_r;
  logic [ADDR_W-1:0]    drp_addr_r;
  logic [DATA_W-1:0]    drp_wdata_r;
  logic [NUM_PORTS-1:0] req_done_r;
  logic [NUM_PORTS-1:0] req_timeout_r;
  logic [DATA_W-1:0]    req_rdata_r;

  logic                 sel_vld;
  logic [GW-1:0]        sel_idx;
  logic [GW-1:0]        scan_idx;
  logic                 finish;
  logic                 timed;

  // Completion happens on a real done, or on the last watchdog cycle; a done
  // arriving on that same last cycle wins over the timeout.
  assign finish = (state == S_WAIT) && (bus.drp_done || (to_cnt == TO_LAST));
  assign timed  = (state == S_WAIT) && !bus.drp_done && (to_cnt == TO_LAST);

  // Pick the first pending slot scanning upward from the port after last_grant.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_idx = GW'((int'(last_grant) + k) % NUM_PORTS);
      if (!sel_vld && slot_vld[scan_idx]) begin
        sel_vld = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

  // Slot occupancy: filled by a request into an empty slot, emptied on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (finish && (grant == GW'(i)))
          slot_vld[i] <= 1'b0;
        else if (bus.req_en[i] && !slot_vld[i])
          slot_vld[i] <= 1'b1;
      end
    end
  end

  // Slot payload: captured only when the slot accepts the request.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.req_en[i] && !slot_vld[i]) begin
        slot_wr[i]    <= bus.req_wr[i];
        slot_addr[i]  <= bus.req_addr[i*ADDR_W +: ADDR_W];
        slot_wdata[i] <= bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Issue/wait FSM with registered DRP strobes and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      grant         <= '0;
      last_grant    <= GW'(NUM_PORTS - 1);
      to_cnt        <= '0;
      drp_en_r      <= 1'b0;
      drp_wr_r      <= 1'b0;
      drp_addr_r    <= '0;
      drp_wdata_r   <= '0;
      req_done_r    <= '0;
      req_timeout_r <= '0;
      req_rdata_r   <= '0;
    end else begin
      drp_en_r      <= 1'b0;
      req_done_r    <= '0;
      req_timeout_r <= '0;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            drp_en_r    <= 1'b1;
            drp_wr_r    <= slot_wr[sel_idx];
            drp_addr_r  <= slot_addr[sel_idx];
            drp_wdata_r <= slot_wdata[sel_idx];
            grant       <= sel_idx;
            to_cnt      <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (finish) begin
            req_done_r[grant]    <= 1'b1;
            req_timeout_r[grant] <= timed;
            req_rdata_r          <= timed ? TIMEOUT_DATA : bus.drp_rdata;
            last_grant           <= grant;
            state                <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_busy    = slot_vld;
  assign bus.req_done    = req_done_r;
  assign bus.req_timeout = req_timeout_r;
  assign bus.req_rdata   = req_rdata_r;
  assign bus.drp_en      = drp_en_r;
  assign bus.drp_wr      = drp_wr_r;
  assign bus.drp_addr    = drp_addr_r;
  assign bus.drp_wdata   = drp_wdata_r;
endmodule

// File: tb/tb_drp_arbiter.sv
// Bench for drp_arbiter: table of single transactions plus hand sequences for
// arbitration order, request overrun and reset mid-transaction. A DRP
// responder model answers each drp_en after a programmable delay.
module tb_drp_arbiter;
  localparam int NP = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  drp_arbiter_if #(.NUM_PORTS(NP)) bus ();

  drp_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO), .TIMEOUT_DATA(16'hdead)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        wr;
    logic [8:0]  addr;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] resp;
    logic [15:0] exp_rdata;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [15:0] wdata;
  } drp_t;

  typedef struct {
    int          port;
    logic [15:0] rdata;
    logic        to;
    int          lat;
  } cpl_t;

  drp_t exp_drp[$];
  cpl_t exp_cpl[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cyc = 0;

  int          resp_delay = 1;
  logic [15:0] resp_rdata = '0;
  logic        stray = 1'b0;
  int          rcnt = -1;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // DRP responder: done arrives 'resp_delay' cycles after drp_en (never if <0).
  always @(posedge clk) begin
    #1;
    if (rst) begin
      rcnt = -1;
      bus.drp_done = 1'b0;
      bus.drp_rdata = '0;
    end else begin
      bus.drp_done = stray;
      if (bus.drp_en) begin
        rcnt = resp_delay;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          bus.drp_done  = 1'b1;
          bus.drp_rdata = resp_rdata;
          rcnt = -1;
        end
      end
    end
  end

  drp_t md;
  cpl_t mc;

  // Scoreboard: compare every DRP issue and every completion against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.drp_en) begin
        if (exp_drp.size() == 0) begin
          chk("unexp_drp_en", 32'(bus.drp_en), 32'd0);
        end else begin
          md = exp_drp.pop_front();
          chk("drp_wr", 32'(bus.drp_wr), 32'(md.wr));
          chk("drp_addr", 32'(bus.drp_addr), 32'(md.addr));
          chk("drp_wdata", 32'(bus.drp_wdata), 32'(md.wdata));
          en_cyc = cyc;
        end
      end
      if ((bus.req_done != '0) || (bus.req_timeout != '0)) begin
        if (exp_cpl.size() == 0) begin
          chk("unexp_done", {24'd0, bus.req_done, bus.req_timeout}, 32'd0);
        end else begin
          mc = exp_cpl.pop_front();
          chk("req_done", 32'(bus.req_done), 32'(1) << mc.port);
          chk("req_timeout", 32'(bus.req_timeout), mc.to ? (32'(1) << mc.port) : 32'd0);
          chk("req_rdata", 32'(bus.req_rdata), 32'(mc.rdata));
          chk("done_latency", 32'(cyc - en_cyc), 32'(mc.lat));
        end
      end
    end
  end

  task automatic set_port(input int p, input logic wr, input logic [8:0] a, input logic [15:0] d);
    bus.req_en[p]            = 1'b1;
    bus.req_wr[p]            = wr;
    bus.req_addr[p*9 +: 9]   = a;
    bus.req_wdata[p*16 +: 16] = d;
  endtask

  task automatic push_drp(input logic wr, input logic [8:0] a, input logic [15:0] d);
    drp_t x;
    x.wr = wr; x.addr = a; x.wdata = d;
    exp_drp.push_back(x);
  endtask

  task automatic push_cpl(input int p, input logic [15:0] rd, input logic to, input int lat);
    cpl_t x;
    x.port = p; x.rdata = rd; x.to = to; x.lat = lat;
    exp_cpl.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_drp.size() != 0 || exp_cpl.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("drain_timeout", 32'(exp_drp.size() + exp_cpl.size()), 32'd0);
      exp_drp.delete();
      exp_cpl.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    resp_delay = v.delay;
    resp_rdata = v.resp;
    push_drp(v.wr, v.addr, v.wdata);
    push_cpl(v.port, v.exp_rdata, v.exp_to, v.exp_lat);
    @(negedge clk);
    set_port(v.port, v.wr, v.addr, v.wdata);
    @(negedge clk);
    bus.req_en = '0;
    chk("busy_after_req", 32'(bus.req_busy), 32'(1) << v.port);
    chk("drp_en_early", 32'(bus.drp_en), 32'd0);
    @(negedge clk);
    chk("drp_en_latency", 32'(bus.drp_en), 32'd1);
    drain();
    chk("busy_cleared", 32'(bus.req_busy), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    int   n;
    //          port wr    addr    wdata     dly resp      exp_rdata  to    lat
    vecs[0] = '{2, 1'b0, 9'h05E, 16'h0000, 3,  16'h1234, 16'h1234, 1'b0, 4};
    vecs[1] = '{0, 1'b1, 9'h100, 16'h5A5A, 1,  16'h0BAD, 16'h0BAD, 1'b0, 2};
    vecs[2] = '{3, 1'b0, 9'h1FF, 16'h0000, 15, 16'h7777, 16'h7777, 1'b0, 16};
    vecs[3] = '{1, 1'b0, 9'h0AA, 16'h0000, 16, 16'h4321, 16'hDEAD, 1'b1, 16};
    vecs[4] = '{1, 1'b1, 9'h0AB, 16'hFFFF, 2,  16'h2222, 16'h2222, 1'b0, 3};
    vecs[5] = '{3, 1'b0, 9'h000, 16'h0000, 14, 16'h8001, 16'h8001, 1'b0, 15};

    bus.req_en = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_drp_en", 32'(bus.drp_en), 32'd0);
    chk("rst_drp_wr", 32'(bus.drp_wr), 32'd0);
    chk("rst_drp_addr", 32'(bus.drp_addr), 32'd0);
    chk("rst_drp_wdata", 32'(bus.drp_wdata), 32'd0);
    chk("rst_busy", 32'(bus.req_busy), 32'd0);
    chk("rst_done", 32'(bus.req_done), 32'd0);
    chk("rst_timeout", 32'(bus.req_timeout), 32'd0);
    chk("rst_rdata", 32'(bus.req_rdata), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous requests right after reset: port 0 first, then 1, then 3.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    resp_delay = 2; resp_rdata = 16'h0001;
    push_drp(1'b1, 9'h010, 16'hAAAA); push_cpl(0, 16'h0001, 1'b0, 3);
    push_drp(1'b1, 9'h011, 16'hBBBB); push_cpl(1, 16'h0001, 1'b0, 3);
    push_drp(1'b1, 9'h013, 16'hCCCC); push_cpl(3, 16'h0001, 1'b0, 3);
    @(negedge clk);
    set_port(0, 1'b1, 9'h010, 16'hAAAA);
    set_port(1, 1'b1, 9'h011, 16'hBBBB);
    set_port(3, 1'b1, 9'h013, 16'hCCCC);
    @(negedge clk); bus.req_en = '0;
    drain();
    // last_grant is 3, so the scan starts at port 0 ahead of port 3.
    resp_rdata = 16'h0002;
    push_drp(1'b1, 9'h010, 16'h1111); push_cpl(0, 16'h0002, 1'b0, 3);
    push_drp(1'b1, 9'h013, 16'h3333); push_cpl(3, 16'h0002, 1'b0, 3);
    @(negedge clk);
    set_port(3, 1'b1, 9'h013, 16'h3333);
    set_port(0, 1'b1, 9'h010, 16'h1111);
    @(negedge clk); bus.req_en = '0;
    drain();
    repeat (4) @(negedge clk);

    // Overrun: a second request from port 1 while its slot is occupied is dropped.
    resp_delay = 4; resp_rdata = 16'h5555;
    push_drp(1'b0, 9'h020, 16'h0000); push_cpl(1, 16'h5555, 1'b0, 5);
    @(negedge clk); set_port(1, 1'b0, 9'h020, 16'h0000);
    @(negedge clk); set_port(1, 1'b0, 9'h021, 16'h0000);
    @(negedge clk); bus.req_en = '0;
    drain();
    repeat (8) @(negedge clk);
    chk("overrun_busy", 32'(bus.req_busy), 32'd0);

    // Reset while waiting: no completion, late done ignored.
    resp_delay = -1;
    push_drp(1'b0, 9'h077, 16'h0000);
    @(negedge clk); set_port(2, 1'b0, 9'h077, 16'h0000);
    @(negedge clk); bus.req_en = '0;
    n = 0;
    while (exp_drp.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("midrst_issued", 32'(exp_drp.size()), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.req_busy), 32'd0);
    chk("midrst_drp_addr", 32'(bus.drp_addr), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    repeat (5) @(negedge clk);
    chk("postrst_busy", 32'(bus.req_busy), 32'd0);
    v = '{0, 1'b0, 9'h042, 16'h0000, 2, 16'h9ABC, 16'h9ABC, 1'b0, 3};
    run_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
